// File: rtl/vm2413_pkg.sv
`default_nettype none
// ============================================================================
// Package  : vm2413
// Brief    : Shared types and constants for the VM2413 operator output memory
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package vm2413;

    // Slot index, 0..17 in use (one spare entry in the output memory)
    typedef logic [4:0] SLOT_TYPE;

    // Operator output word: {sign, 9-bit linear magnitude}
    typedef logic [9:0] SIGNED_LI_TYPE;

    // Operator pipeline stage, 0..3 within one slot
    typedef logic [1:0] STAGE_TYPE;

    localparam int NUM_SLOTS   = 18;
    localparam int INIT_CYCLES = 19;

    // Modulator of a carrier slot lives in the slot just before it
    function automatic SLOT_TYPE prev_slot(input SLOT_TYPE s);
        return s - 5'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/outmem_mix_port.sv
`default_nettype none
// ============================================================================
// Module   : outmem_mix_port
// Brief    : Port-2 owner of the output memory. Operator modulator fetch in
//            stages 0-1, mixer read window in stages 2-3 with a grant latch
//            and a two-stage capture/ack pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module outmem_mix_port
    import vm2413::*;
#(
    parameter int NUM_SLOTS = vm2413::NUM_SLOTS
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          run,
    input  STAGE_TYPE     stage,
    input  logic          stage_new,
    input  SLOT_TYPE      slot,
    input  logic          mix_req,
    input  SLOT_TYPE      mix_slot,
    input  SIGNED_LI_TYPE mem_rdata2,
    output logic          mix_ack,
    output SIGNED_LI_TYPE mix_data,
    output SLOT_TYPE      mem_addr2
);

    localparam SLOT_TYPE c_num_slots = SLOT_TYPE'(NUM_SLOTS);

    logic          w_grant;
    SLOT_TYPE      w_addr2;
    logic          r_granted;
    SLOT_TYPE      r_gnt_slot;
    logic          r_gnt_oor;
    logic          r_rd_issue;
    logic          r_rd_valid;
    logic          r_ack;
    SIGNED_LI_TYPE r_data;

    // Only the first clk of stage 2 can grant, which also limits it to one per slot
    assign w_grant = run && (stage == 2'd2) && stage_new && mix_req;

    // Grant latch: holds the mixer address until the operator reclaims the port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_granted  <= 1'b0;
            r_gnt_slot <= '0;
            r_gnt_oor  <= 1'b0;
        end else if (w_grant) begin
            r_granted  <= 1'b1;
            r_gnt_slot <= mix_slot;
            r_gnt_oor  <= (mix_slot >= c_num_slots);
        end else if (stage == 2'd0) begin
            r_granted  <= 1'b0;
        end
    end

    // Read pipeline: address issued, memory data valid, then capture with ack
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_issue <= 1'b0;
            r_rd_valid <= 1'b0;
            r_ack      <= 1'b0;
            r_data     <= '0;
        end else begin
            r_rd_issue <= w_grant;
            r_rd_valid <= r_rd_issue;
            r_ack      <= r_rd_valid;
            if (r_rd_valid) begin
                r_data <= r_gnt_oor ? '0 : mem_rdata2;
            end
        end
    end

    // Address mux; out-of-range mixer slots never reach the memory
    always_comb begin
        w_addr2 = slot;
        if (stage[1]) begin
            if (r_granted && !r_gnt_oor) begin
                w_addr2 = r_gnt_slot;
            end
        end else if (slot[0]) begin
            w_addr2 = prev_slot(slot);
        end
    end

    assign mem_addr2 = w_addr2;
    assign mix_ack   = r_ack;
    assign mix_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/outmem_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : outmem_scheduler
// Brief    : Sequencer for the VM2413 per-slot operator output memory. Runs
//            the 18-slot x 4-stage timeline, writes operator results back,
//            fetches feedback/modulator operands and shares port 2 with the
//            channel mixer.
// Revision : 1.0 - initial release
// ============================================================================
module outmem_scheduler
    import vm2413::*;
#(
    parameter int NUM_SLOTS   = vm2413::NUM_SLOTS,
    parameter int INIT_CYCLES = vm2413::INIT_CYCLES
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clkena,
    input  logic          op_valid,
    input  SIGNED_LI_TYPE op_data,
    input  logic          mix_req,
    input  SLOT_TYPE      mix_slot,
    output logic          mix_ack,
    output SIGNED_LI_TYPE mix_data,
    output SLOT_TYPE      slot,
    output STAGE_TYPE     stage,
    output SIGNED_LI_TYPE fb_data,
    output SIGNED_LI_TYPE mod_data,
    output logic          sample_strobe,
    output logic          init_busy,
    output logic          mem_wr,
    output SLOT_TYPE      mem_addr,
    output SIGNED_LI_TYPE mem_wdata,
    input  SIGNED_LI_TYPE mem_rdata,
    output SLOT_TYPE      mem_addr2,
    input  SIGNED_LI_TYPE mem_rdata2
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int                 c_cnt_w     = $clog2(INIT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_init_last = c_cnt_w'(INIT_CYCLES - 1);
    localparam SLOT_TYPE           c_last_slot = SLOT_TYPE'(NUM_SLOTS - 1);

    logic [0:0]         r_state;
    logic [c_cnt_w-1:0] r_init_cnt;
    SLOT_TYPE           r_slot;
    STAGE_TYPE          r_stage;
    logic               r_stage_new;
    logic               r_strobe;
    SIGNED_LI_TYPE      r_fb;
    SIGNED_LI_TYPE      r_mod;
    logic               w_run;
    logic               w_advance;
    logic               w_wr;

    assign w_run     = (r_state == ST_RUN);
    assign w_advance = w_run && clkena;

    // INIT/RUN sequencer with slot/stage counters and the frame strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_INIT;
            r_init_cnt  <= '0;
            r_slot      <= '0;
            r_stage     <= '0;
            r_stage_new <= 1'b0;
            r_strobe    <= 1'b0;
        end else begin
            r_stage_new <= 1'b0;
            r_strobe    <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    // Memory self-clear runs on every clk, so clkena is ignored here
                    if (r_init_cnt == c_init_last) begin
                        r_state     <= ST_RUN;
                        r_stage_new <= 1'b1;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                default: begin
                    if (clkena) begin
                        r_stage     <= r_stage + 2'd1;
                        r_stage_new <= 1'b1;
                        if (r_stage == 2'd3) begin
                            if (r_slot == c_last_slot) begin
                                r_slot   <= '0;
                                r_strobe <= 1'b1;
                            end else begin
                                r_slot <= r_slot + 5'd1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Operand capture on the edge leaving stage 1; modulator only for carriers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fb  <= '0;
            r_mod <= '0;
        end else if (w_advance && (r_stage == 2'd1)) begin
            r_fb <= mem_rdata;
            if (r_slot[0]) begin
                r_mod <= mem_rdata2;
            end
        end
    end

    // Write-back lands on the edge leaving stage 3 of the slot
    assign w_wr      = w_advance && (r_stage == 2'd3) && op_valid;
    assign mem_wr    = w_wr;
    assign mem_wdata = w_wr ? op_data : '0;
    assign mem_addr  = r_slot;

    assign slot          = r_slot;
    assign stage         = r_stage;
    assign init_busy     = !w_run;
    assign sample_strobe = r_strobe;
    assign fb_data       = r_fb;
    assign mod_data      = r_mod;

    outmem_mix_port #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_mix_port (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (w_run),
        .stage      (r_stage),
        .stage_new  (r_stage_new),
        .slot       (r_slot),
        .mix_req    (mix_req),
        .mix_slot   (mix_slot),
        .mem_rdata2 (mem_rdata2),
        .mix_ack    (mix_ack),
        .mix_data   (mix_data),
        .mem_addr2  (mem_addr2)
    );

endmodule
`default_nettype wire

// File: tb/tb_outmem_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_outmem_scheduler
// Brief    : Scoreboard bench for outmem_scheduler with a behavioural model of
//            the 19-entry output memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_outmem_scheduler;
    import vm2413::*;

    typedef struct packed {
        SLOT_TYPE      addr;
        SIGNED_LI_TYPE data;
    } wr_t;

    logic          clk      = 1'b0;
    logic          reset_n  = 1'b1;
    logic          clkena   = 1'b1;
    logic          op_valid = 1'b0;
    SIGNED_LI_TYPE op_data  = '0;
    logic          mix_req  = 1'b0;
    SLOT_TYPE      mix_slot = '0;
    logic          mix_ack;
    SIGNED_LI_TYPE mix_data;
    SLOT_TYPE      slot;
    STAGE_TYPE     stage;
    SIGNED_LI_TYPE fb_data;
    SIGNED_LI_TYPE mod_data;
    logic          sample_strobe;
    logic          init_busy;
    logic          mem_wr;
    SLOT_TYPE      mem_addr;
    SIGNED_LI_TYPE mem_wdata;
    SIGNED_LI_TYPE mem_rdata;
    SLOT_TYPE      mem_addr2;
    SIGNED_LI_TYPE mem_rdata2;

    int            n_cmp     = 0;
    int            n_bad     = 0;
    int            cyc       = 0;
    bit            toggle_en = 1'b0;
    bit            bad_addr2 = 1'b0;
    SIGNED_LI_TYPE exp_mix[$];
    wr_t           exp_wr[$];
    wr_t           wr_pop;
    SIGNED_LI_TYPE mix_pop;
    SIGNED_LI_TYPE mem [0:18];

    outmem_scheduler dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .clkena        (clkena),
        .op_valid      (op_valid),
        .op_data       (op_data),
        .mix_req       (mix_req),
        .mix_slot      (mix_slot),
        .mix_ack       (mix_ack),
        .mix_data      (mix_data),
        .slot          (slot),
        .stage         (stage),
        .fb_data       (fb_data),
        .mod_data      (mod_data),
        .sample_strobe (sample_strobe),
        .init_busy     (init_busy),
        .mem_wr        (mem_wr),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_addr2     (mem_addr2),
        .mem_rdata2    (mem_rdata2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output memory model: registered reads, cleared whenever reset is applied
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 19; i++) mem[i] <= '0;
            mem_rdata  <= '0;
            mem_rdata2 <= '0;
        end else begin
            if (mem_wr && mem_addr < 5'd19) mem[mem_addr] <= mem_wdata;
            mem_rdata  <= (mem_addr  < 5'd19) ? mem[mem_addr]  : '0;
            mem_rdata2 <= (mem_addr2 < 5'd19) ? mem[mem_addr2] : '0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected writes and mixer reads as the DUT presents them
    always @(negedge clk) begin
        if (mem_wr) begin
            if (exp_wr.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected write: addr %0d data %0h, required no write", mem_addr, mem_wdata);
            end else begin
                wr_pop = exp_wr.pop_front();
                chk("write addr", 32'(mem_addr), 32'(wr_pop.addr));
                chk("write data", 32'(mem_wdata), 32'(wr_pop.data));
            end
        end
        if (mix_ack) begin
            if (exp_mix.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected mix_ack: data %0h, required no ack", mix_data);
            end else begin
                mix_pop = exp_mix.pop_front();
                chk("mix_data", 32'(mix_data), 32'(mix_pop));
            end
        end
        if (reset_n && !init_busy && mem_addr2 >= 5'd18) bad_addr2 = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_en) clkena = ~clkena;
    endtask

    task automatic wait_pos(input int s, input int g);
        int n = 0;
        while (!(slot == s && stage == g) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) chk("wait_pos timeout slot/stage", {slot, stage}, 32'((s << 2) | g));
    endtask

    task automatic init_count(input string name);
        int n = 0;
        bit busy_act = 1'b0;
        @(negedge clk);
        while (init_busy && n < 100) begin
            if (mem_wr || mix_ack) busy_act = 1'b1;
            n++;
            @(negedge clk);
        end
        chk({name, " init clks"}, n, 19);
        chk({name, " wr/ack during init"}, busy_act, 0);
        chk({name, " first run slot/stage"}, {slot, stage}, 0);
    endtask

    task automatic wait_stage2_entry(input string name);
        int n = 0;
        STAGE_TYPE prev;
        do begin
            prev = stage;
            tick();
            n++;
        end while (!(stage == 2'd2 && prev != 2'd2) && n < 400);
        if (n >= 400) chk({name, " stage2 reached"}, stage, 2);
    endtask

    task automatic mix_read(input SLOT_TYPE ms, input SIGNED_LI_TYPE exp_d, input string name);
        int n = 0;
        mix_slot = ms;
        mix_req  = 1'b1;
        exp_mix.push_back(exp_d);
        wait_stage2_entry(name);
        while (!mix_ack && n < 10) begin
            tick();
            n++;
        end
        chk({name, " ack latency"}, n, 3);
        mix_req = 1'b0;
        tick();
        chk({name, " ack width"}, mix_ack, 0);
    endtask

    task automatic write_op(input int s, input SIGNED_LI_TYPE d);
        wait_pos(s, 3);
        op_valid = 1'b1;
        op_data  = d;
        exp_wr.push_back('{addr: SLOT_TYPE'(s), data: d});
        tick();
        op_valid = 1'b0;
        op_data  = '0;
    endtask

    initial begin
        int t0;
        int n;
        // Asynchronous reset state
        #1 reset_n = 1'b0;
        #1;
        chk("reset init_busy", init_busy, 1);
        chk("reset slot/stage", {slot, stage}, 0);
        chk("reset mem_wr/ack/strobe", {mem_wr, mix_ack, sample_strobe}, 0);
        chk("reset fb/mod/mix_data", {fb_data, mod_data, mix_data}, 0);
        chk("reset mem_addr2", mem_addr2, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        init_count("first");

        // Frame timing: 72 clks between strobes
        t0 = cyc;
        n  = 0;
        do begin tick(); n++; end while (!sample_strobe && n < 200);
        chk("frame1 length", cyc - t0, 72);
        chk("strobe at slot0 stage0", {slot, stage}, 0);
        t0 = cyc;
        n  = 0;
        do begin tick(); n++; end while (!sample_strobe && n < 200);
        chk("frame2 length", cyc - t0, 72);

        // Write-back, feedback and modulator read-after-write
        wait_pos(5, 2);
        chk("fb slot5 before write", fb_data, 0);
        write_op(5, 10'h155);
        write_op(6, 10'h0AA);
        wait_pos(7, 2);
        chk("mod slot7 after slot6 write", mod_data, 10'h0AA);
        chk("fb slot7 empty", fb_data, 0);
        wait_pos(8, 2);
        chk("mod holds on even slot8", mod_data, 10'h0AA);
        wait_pos(9, 2);
        chk("mod slot9 from empty slot8", mod_data, 0);
        write_op(3, 10'h1C3);
        wait_pos(5, 2);
        chk("fb slot5 next frame", fb_data, 10'h155);
        chk("mod slot5 from slot4", mod_data, 0);

        // Mixer reads: steady clkena, toggling clkena, out-of-range slot
        wait_pos(10, 0);
        mix_read(5'd3, 10'h1C3, "mix slot3");
        wait_pos(12, 0);
        toggle_en = 1'b1;
        mix_read(5'd5, 10'h155, "mix slot5 toggled");
        toggle_en = 1'b0;
        clkena    = 1'b1;
        wait_pos(14, 3);
        mix_read(5'd20, 10'h000, "mix slot20");

        // Reset between grant and ack: request is dropped, INIT restarts
        wait_pos(10, 0);
        mix_slot = 5'd3;
        mix_req  = 1'b1;
        wait_stage2_entry("abort");
        tick();
        reset_n = 1'b0;
        #1;
        chk("abort init_busy", init_busy, 1);
        chk("abort slot/stage/ack", {slot, stage, mix_ack}, 0);
        mix_req = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        init_count("after abort");
        repeat (30) tick();

        chk("mem_addr2 out-of-range seen", bad_addr2, 0);
        chk("pending mixer acks", exp_mix.size(), 0);
        chk("pending writes", exp_wr.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/outmem_scheduler.md
# outmem_scheduler

Sequencer and arbiter for the VM2413 per-slot operator output memory (19 entries × SIGNED_LI_TYPE, one write/read port, one extra read port, one-clk registered reads, self-clearing entries 0–17 during the first 18 clks after reset). Runs the 18-slot × 4-stage operator timeline. On that timeline it:
- writes each operator result back to memory;
- fetches feedback and modulator operands for the operator pipeline;
- time-shares the second read port with the channel mixer through a req/ack handshake.

## Interface
Parameters:
- NUM_SLOTS, 18, slots per sample frame; slot index wraps 17→0.
- INIT_CYCLES, 19, clks held in INIT after reset release; covers the memory self-clear.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- clkena  in  1  stage-advance enable; the memory itself is clocked every clk.
- op_valid  in  1  operator result valid; sampled only in stage 3.
- op_data  in  SIGNED_LI_TYPE  operator result for the current slot.
- mix_req  in  1  mixer read request; level, held until mix_ack.
- mix_slot  in  SLOT_TYPE  slot the mixer wants; stable while mix_req=1.
- mix_ack  out  1  one-clk pulse; mix_data valid in the same clk.
- mix_data  out  SIGNED_LI_TYPE  registered read result for the mixer.
- slot  out  SLOT_TYPE  current slot, 0–17.
- stage  out  2  current stage, 0–3.
- fb_data  out  SIGNED_LI_TYPE  previous output of the current slot.
- mod_data  out  SIGNED_LI_TYPE  output of slot−1; updated on odd (carrier) slots only.
- sample_strobe  out  1  one-clk pulse at frame wrap.
- init_busy  out  1  high while in INIT.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  SLOT_TYPE  memory port-1 address.
- mem_wdata  out  SIGNED_LI_TYPE  memory write data.
- mem_rdata  in  SIGNED_LI_TYPE  memory port-1 read data.
- mem_addr2  out  SLOT_TYPE  memory port-2 address.
- mem_rdata2  in  SIGNED_LI_TYPE  memory port-2 read data.

## Operation
- **FSM.**
  - States: INIT → RUN.
  - INIT counts INIT_CYCLES clks regardless of clkena. During INIT: init_busy=1, mem_wr=0, slot=stage=0, no acks.
  - RUN: stage increments on clk when clkena=1. Stage 3→0 increments slot. Slot 17, stage 3→0 wraps to 0 and pulses sample_strobe.
- **Port 1.**
  - mem_addr=slot for the whole slot.
  - Stage 3 with clkena and op_valid: mem_wr=1 for one clk, mem_wdata=op_data. op_valid in other stages is ignored.
  - fb_data captures mem_rdata on the edge leaving stage 1.
- **Port 2, operator-owned (stages 0–1).**
  - Odd slot: mem_addr2=slot−1; mod_data captures mem_rdata2 on the edge leaving stage 1.
  - Even slot: mem_addr2 is don't-care and mod_data holds.
- **Port 2, mixer-owned (stages 2–3).**
  - Grant: first clk of stage 2 with mix_req=1. At most one grant per slot.
  - Granted request: mem_addr2=mix_slot, held until stage 0.
  - Capture: mix_data ← mem_rdata2 two clks after the grant edge; mix_ack pulses in that clk.
  - mix_slot ≥ 18: no memory access; mix_data=0; ack timing unchanged.
  - A request not granted stays pending to the next slot's stage 2.
- **Read-after-write.** A slot-(n−1) write on the edge leaving stage 3 is visible to the slot-n modulator read.

## Timing
- Reset (async assert) values:
  - All outputs 0, except init_busy=1.
  - FSM in INIT.
  - No pending mixer grant.
- Reset asserted mid-frame or mid-handshake: abort immediately and re-enter INIT. Pending acks are lost; the mixer re-requests.
- RUN begins on the clk after the INIT_CYCLES-th clk following release.
- Mixer latency: grant edge to mix_ack is 2 clks. Each stage lasts at least 1 clk, so capture always lands before the next stage 0 reclaims port 2.
- clkena=0 stretches stages. Addresses hold, and captures occur only on the specified stage-exit edges.

## Structure
- Add to package vm2413: NUM_SLOTS, INIT_CYCLES, STAGE_TYPE (2-bit). Reuse SLOT_TYPE and SIGNED_LI_TYPE.
- One sub-module, outmem_mix_port: grant latch, port-2 address mux, two-stage capture/ack pipeline.
- The top level holds the FSM, slot/stage counters and port-1 logic.

## Test plan
- **Reset and INIT.** Release reset_n with clkena=1 → init_busy=1 for 19 clks, no mem_wr; slot=0/stage=0 on the first RUN clk.
- **Frame timing.** clkena=1 constantly → 72-clk frame, sample_strobe every 72 clks.
- **Write and feedback.** op_valid=1, op_data=0x155 in slot 5 stage 3 → mem_wr at addr 5. Next frame: fb_data=0x155 in slot 5 after stage 1.
- **Modulator read-after-write.** Write 0x0AA to slot 6 → in slot 7, mod_data=0x0AA after stage 1.
- **Mixer handshake and wait.** mix_req with mix_slot=3 raised in stage 0 → grant at stage 2, mix_ack 2 clks later with the slot-3 contents. With clkena toggling 1/0, ack still arrives before stage 0.
- **Mixer out of range and reset abort.** mix_slot=20 → ack with mix_data=0 and mem_addr2 never driven to 20. reset_n pulsed low between grant and ack → no ack; init_busy=1 and INIT restarts.
